// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
//   - uart_state_e : receive FSM states
//   - bit-centre tick positions (16x oversampling) and the counts at which
//     each bit is decided (one tick after its centre, once the third majority
//     sample is available)
//   - default parity seed for the paritymode parameter
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } uart_state_e;

    localparam int unsigned OVERSAMPLE        = 16;
    localparam int unsigned DATA_BITS         = 8;
    localparam int unsigned START_CENTRE      = 8;
    localparam int unsigned FIRST_DATA_CENTRE = 24;
    localparam int unsigned PARITY_CENTRE     = 152;
    localparam int unsigned STOP_CENTRE       = 168;

    localparam logic PARITYMODE_DEFAULT = 1'b0;

    // A bit is decided on the tick after its centre: the majority window is
    // centre-1, centre, centre+1 and the newest sample arrives at centre+1.
    function automatic logic [7:0] decide_tick(int unsigned centre);
        return 8'(centre + 1);
    endfunction

    localparam logic [7:0] START_DECIDE     = decide_tick(START_CENTRE);
    localparam logic [7:0] LAST_DATA_DECIDE =
        decide_tick(FIRST_DATA_CENTRE + (DATA_BITS - 1) * OVERSAMPLE);
    localparam logic [7:0] PARITY_DECIDE    = decide_tick(PARITY_CENTRE);
    localparam logic [7:0] STOP_DECIDE      = decide_tick(STOP_CENTRE);

    // Every bit decision lands on the same low-nibble phase of the counter.
    localparam logic [3:0] BIT_PHASE = 4'(FIRST_DATA_CENTRE + 1);

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result interface.
//   Data_Rx    : last received byte
//   Rddone     : one-cycle frame-complete strobe
//   Busy       : frame in progress
//   Parity_Err : parity mismatch of the last frame
//   Frame_Err  : stop bit of the last frame sampled low
// master = receiver (drives everything), slave = consumer.
interface uart_rx_if ();

    logic [uart_pkg::DATA_BITS-1:0] Data_Rx;
    logic                           Rddone;
    logic                           Busy;
    logic                           Parity_Err;
    logic                           Frame_Err;

    modport master (
        output Data_Rx,
        output Rddone,
        output Busy,
        output Parity_Err,
        output Frame_Err
    );

    modport slave (
        input Data_Rx,
        input Rddone,
        input Busy,
        input Parity_Err,
        input Frame_Err
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Line front end for the UART receiver.
//   Uart_CLK  : 16x oversample clock
//   Rst_n     : synchronous active-low reset (all flops reset to line idle, 1)
//   Signal_Rx : raw asynchronous serial line
//   rx_sync   : synchronized line value
//   fall_edge : synchronized 1->0 transition seen this cycle
//   majority  : 2-of-3 vote over the synchronized samples of this cycle and
//               the two before it
module uart_rx_sync (
    input  logic Uart_CLK,
    input  logic Rst_n,
    input  logic Signal_Rx,
    output logic rx_sync,
    output logic fall_edge,
    output logic majority
);

    logic       meta_q;
    logic       sync_q;
    // hist_q[0]: synchronized sample one cycle ago, hist_q[1]: two cycles ago
    logic [1:0] hist_q;

    always_ff @(posedge Uart_CLK) begin
        if (!Rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 2'b11;
        end else begin
            meta_q <= Signal_Rx;
            sync_q <= meta_q;
            hist_q <= {hist_q[0], sync_q};
        end
    end

    assign rx_sync   = sync_q;
    assign fall_edge = hist_q[0] & ~sync_q;
    assign majority  = (hist_q[1] & hist_q[0]) |
                       (hist_q[1] & sync_q)    |
                       (hist_q[0] & sync_q);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits (LSB first), parity, stop at 16 ticks/bit.
//   Uart_CLK  : sole clock, 16x baud oversample tick
//   Rst_n     : synchronous active-low reset
//   Signal_Rx : serial line, idle high, asynchronous
//   rx_if     : result interface (Data_Rx, Rddone, Busy, Parity_Err, Frame_Err)
// Parameter paritymode seeds the parity: expected bit = XOR(data) ^ paritymode.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic paritymode = PARITYMODE_DEFAULT
) (
    input  logic     Uart_CLK,
    input  logic     Rst_n,
    input  logic     Signal_Rx,
    uart_rx_if.master rx_if
);

    logic rx_sync;
    logic fall_edge;
    logic majority;

    uart_rx_sync u_sync (
        .Uart_CLK  (Uart_CLK),
        .Rst_n     (Rst_n),
        .Signal_Rx (Signal_Rx),
        .rx_sync   (rx_sync),
        .fall_edge (fall_edge),
        .majority  (majority)
    );

    uart_state_e          state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 par_pend_q, par_pend_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 rddone_q, rddone_d;

    always_ff @(posedge Uart_CLK) begin
        if (!Rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            par_pend_q <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rddone_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            par_pend_q <= par_pend_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            rddone_q   <= rddone_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        par_pend_d = par_pend_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        rddone_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fall_edge) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end

            StStart: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == START_DECIDE) begin
                    if (majority) begin
                        // Start bit did not hold low: treat as a glitch.
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        par_acc_d = paritymode;
                    end
                end
            end

            StData: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q[3:0] == BIT_PHASE) begin
                    shift_d   = {majority, shift_q[DATA_BITS-1:1]};
                    par_acc_d = par_acc_q ^ majority;
                    if (cnt_q == LAST_DATA_DECIDE) begin
                        state_d = StParity;
                    end
                end
            end

            StParity: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == PARITY_DECIDE) begin
                    // par_acc_q already holds the expected parity bit.
                    par_pend_d = majority ^ par_acc_q;
                    state_d    = StStop;
                end
            end

            StStop: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == STOP_DECIDE) begin
                    data_d   = shift_q;
                    perr_d   = par_pend_q;
                    ferr_d   = ~majority;
                    rddone_d = 1'b1;
                    state_d  = majority ? StIdle : StBreak;
                end
            end

            StBreak: begin
                // Wait out a held-low line; falling edges are meaningless here.
                if (rx_sync) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_if.Data_Rx    = data_q;
    assign rx_if.Rddone     = rddone_q;
    assign rx_if.Parity_Err = perr_q;
    assign rx_if.Frame_Err  = ferr_q;
    // The state leaves StStop on the same edge that raises Rddone, so Busy
    // drops exactly when the strobe appears.
    assign rx_if.Busy       = (state_q == StStart)  || (state_q == StData) ||
                              (state_q == StParity) || (state_q == StStop);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx. Two receivers share the serial line, one per
// parity seed, so every frame is checked under both parity modes.
module tb_uart_rx;
    import uart_pkg::*;

    logic Uart_CLK  = 1'b0;
    logic Rst_n     = 1'b0;
    logic Signal_Rx = 1'b1;

    always #5 Uart_CLK = ~Uart_CLK;

    uart_rx_if if0 ();
    uart_rx_if if1 ();

    uart_rx #(.paritymode(1'b0)) dut0 (
        .Uart_CLK  (Uart_CLK),
        .Rst_n     (Rst_n),
        .Signal_Rx (Signal_Rx),
        .rx_if     (if0.master)
    );

    uart_rx #(.paritymode(1'b1)) dut1 (
        .Uart_CLK  (Uart_CLK),
        .Rst_n     (Rst_n),
        .Signal_Rx (Signal_Rx),
        .rx_if     (if1.master)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int errors = 0;
    int checks = 0;

    // What each receiver's outputs are expected to be holding right now.
    logic [7:0] held_data [2] = '{8'h00, 8'h00};
    logic       held_perr [2] = '{1'b0, 1'b0};
    logic       held_ferr [2] = '{1'b0, 1'b0};
    logic       prev_rd   [2] = '{1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: a frame yields its byte; parity error when the received
    // parity bit differs from XOR of the byte seeded with paritymode; frame
    // error when the stop bit is low.
    function automatic exp_t model(input logic [7:0] d, input logic pbit, input logic stop,
                                   input logic pm);
        exp_t e;
        e.data = d;
        e.perr = (pbit != ((^d) ^ pm));
        e.ferr = !stop;
        return e;
    endfunction

    task automatic push_expect(input logic [7:0] d, input logic pbit, input logic stop);
        q0.push_back(model(d, pbit, stop, 1'b0));
        q1.push_back(model(d, pbit, stop, 1'b1));
    endtask

    // Monitor: pop and compare on every Rddone; between strobes the outputs
    // must keep their last values.
    task automatic mon(input int id, input logic rd, input logic busy, input logic [7:0] d,
                       input logic pe, input logic fe);
        exp_t e;
        if (!Rst_n) begin
            held_data[id] = 8'h00;
            held_perr[id] = 1'b0;
            held_ferr[id] = 1'b0;
            prev_rd[id]   = 1'b0;
            return;
        end
        if (rd) begin
            check($sformatf("rddone_single_cycle%0d", id), prev_rd[id], 1'b0);
            check($sformatf("busy_low_at_rddone%0d", id), busy, 1'b0);
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rddone%0d: got Rddone=1, required no strobe", id);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                check($sformatf("data%0d", id), d, e.data);
                check($sformatf("parity_err%0d", id), pe, e.perr);
                check($sformatf("frame_err%0d", id), fe, e.ferr);
                held_data[id] = e.data;
                held_perr[id] = e.perr;
                held_ferr[id] = e.ferr;
            end
        end else if (d !== held_data[id] || pe !== held_perr[id] || fe !== held_ferr[id]) begin
            check($sformatf("outputs_hold%0d", id), {d, pe, fe},
                  {held_data[id], held_perr[id], held_ferr[id]});
        end
        prev_rd[id] = rd;
    endtask

    always @(negedge Uart_CLK) begin
        mon(0, if0.Rddone, if0.Busy, if0.Data_Rx, if0.Parity_Err, if0.Frame_Err);
        mon(1, if1.Rddone, if1.Busy, if1.Data_Rx, if1.Parity_Err, if1.Frame_Err);
    end

    task automatic check_reset(input string tag);
        check({tag, "_data0"}, if0.Data_Rx, 8'h00);
        check({tag, "_rddone0"}, if0.Rddone, 1'b0);
        check({tag, "_busy0"}, if0.Busy, 1'b0);
        check({tag, "_perr0"}, if0.Parity_Err, 1'b0);
        check({tag, "_ferr0"}, if0.Frame_Err, 1'b0);
        check({tag, "_data1"}, if1.Data_Rx, 8'h00);
        check({tag, "_rddone1"}, if1.Rddone, 1'b0);
        check({tag, "_busy1"}, if1.Busy, 1'b0);
        check({tag, "_perr1"}, if1.Parity_Err, 1'b0);
        check({tag, "_ferr1"}, if1.Frame_Err, 1'b0);
    endtask

    // Drive one frame tick by tick. glitch_at inverts the line for one tick;
    // abort_at applies reset at that tick and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input int stop_len, input int glitch_at, input int abort_at);
        logic [10:0] bits;
        int          total;
        bits  = {stop, pbit, d, 1'b0};
        total = 10 * OVERSAMPLE + stop_len;
        for (int t = 0; t < total; t++) begin
            int   idx;
            logic b;
            if (t == abort_at) begin
                Rst_n     = 1'b0;
                Signal_Rx = 1'b1;
                repeat (3) @(negedge Uart_CLK);
                check_reset("mid_frame_reset");
                Rst_n = 1'b1;
                repeat (20) @(negedge Uart_CLK);
                return;
            end
            idx = t / OVERSAMPLE;
            if (idx > 10) idx = 10;
            b = bits[idx];
            if (t == glitch_at) b = ~b;
            if (!stop && t == 10 * OVERSAMPLE + 24) begin
                check("busy_in_break0", if0.Busy, 1'b0);
                check("busy_in_break1", if1.Busy, 1'b0);
            end
            Signal_Rx = b;
            @(negedge Uart_CLK);
        end
        if (!stop) begin
            Signal_Rx = 1'b1;
            repeat (OVERSAMPLE) @(negedge Uart_CLK);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(negedge Uart_CLK);
        check_reset("power_on_reset");
        Rst_n = 1'b1;
        repeat (10) @(negedge Uart_CLK);

        // Clean frame, correct parity for seed 0.
        push_expect(8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, OVERSAMPLE, -1, -1);

        // Parity bit forced 0: wrong for seed 0, right for seed 1.
        push_expect(8'h01, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1, OVERSAMPLE, -1, -1);
        repeat (8) @(negedge Uart_CLK);

        // Short low pulse: Busy rises, then the start check rejects it.
        Signal_Rx = 1'b0;
        repeat (5) @(negedge Uart_CLK);
        check("glitch_busy_high0", if0.Busy, 1'b1);
        check("glitch_busy_high1", if1.Busy, 1'b1);
        Signal_Rx = 1'b1;
        repeat (30) @(negedge Uart_CLK);
        check("glitch_busy_low0", if0.Busy, 1'b0);
        check("glitch_busy_low1", if1.Busy, 1'b0);
        check("glitch_data_kept0", if0.Data_Rx, 8'h01);
        check("glitch_data_kept1", if1.Data_Rx, 8'h01);

        // Stop bit held low 40 ticks, then a clean frame after the break.
        push_expect(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 40, -1, -1);
        push_expect(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, OVERSAMPLE, -1, -1);

        // Reset 80 ticks into a frame, then an all-ones byte.
        send_frame(8'h96, 1'b0, 1'b1, OVERSAMPLE, -1, 80);
        push_expect(8'hFF, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, OVERSAMPLE, -1, -1);

        // One-tick high spike at the D3 centre of an all-zero byte.
        push_expect(8'h00, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b1, OVERSAMPLE, 73, -1);

        // Randomized frames, back-to-back or with short gaps.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       pbit;
            logic       stop;
            int         slen;
            d    = 8'($urandom);
            pbit = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            stop = ($urandom_range(0, 5) != 0);
            slen = stop ? OVERSAMPLE : int'($urandom_range(30, 60));
            push_expect(d, pbit, stop);
            send_frame(d, pbit, stop, slen, -1, -1);
            Signal_Rx = 1'b1;
            repeat (5 * $urandom_range(0, 3)) @(negedge Uart_CLK);
        end

        repeat (200) @(negedge Uart_CLK);
        check("all_frames_seen0", q0.size(), 0);
        check("all_frames_seen1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
